// File: rtl/apb2axi_rd_engine.sv
// Purpose : drains the RD request FIFO onto AXI AR and forwards R beats to the response FIFO.
// Latency : a pop raises arvalid on the next cycle. R beats pass through combinationally in the same cycle.
// Backpres: AR holds until arready. Pops stall on the outstanding cap or on a busy head tag. rready follows resp_push_ready.
//
// Ports:
//   aclk, aresetn              clock and asynchronous active-low reset
//   rd_pop_valid/ready/data    RD request FIFO pop side; data is a packed directory_entry_t
//   ar*                        AXI read address channel; arburst is fixed at INCR
//   r*                         AXI read data channel
//   resp_push_valid/ready/data response FIFO push side, carrying {rid, rresp, rlast, rdata}
//   outstanding                number of reads issued on AR and not yet completed by an RLAST beat
//   proto_err                  sticky flag: RLAST beat count mismatch, or a beat on an idle ID
module apb2axi_rd_engine #(
  parameter int ID_W            = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int FIFO_ENTRY_W    = ADDR_W + 8 + 3 + ID_W,
  parameter int MAX_OUTSTANDING = 8,
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // RD request FIFO pop side
  input  logic                      rd_pop_valid,
  output logic                      rd_pop_ready,
  input  logic [FIFO_ENTRY_W-1:0]   rd_pop_data,
  // AXI AR channel
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ADDR_W-1:0]         araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [ID_W-1:0]           arid,
  // AXI R channel
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [ID_W-1:0]           rid,
  input  logic [DATA_W-1:0]         rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  // Response FIFO push side
  output logic                      resp_push_valid,
  input  logic                      resp_push_ready,
  output logic [DATA_W+ID_W+2:0]    resp_push_data,
  // Status
  output logic [OUT_W-1:0]          outstanding,
  output logic                      proto_err
);

  localparam int NUM_IDS = 2 ** ID_W;
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  // Directory entry layout. The tag sits in the LSBs. A wider FIFO word
  // carries extra fields above the ones this block reads.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [ID_W-1:0]   tag;
  } directory_entry_t;

  localparam int ENT_W = $bits(directory_entry_t);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_PEND = 1'b1
  } ar_state_t;

  ar_state_t        ar_state;
  directory_entry_t head;

  // ID table: one entry per AXI ID
  logic [NUM_IDS-1:0] id_busy;
  logic [7:0]         id_exp_len  [NUM_IDS];
  logic [7:0]         id_beat_cnt [NUM_IDS];

  logic       ar_hs;
  logic       r_hs;
  logic       rid_busy;
  logic [7:0] rid_cnt;
  logic [7:0] rid_len;
  logic       r_known;
  logic       r_cmpl;
  logic       r_err;

  assign head = directory_entry_t'(rd_pop_data[ENT_W-1:0]);

  // --------------------------------------------------------------------------
  // Pop qualification.
  // This path is combinational, so reset is ANDed in to hold the strobe low
  // while aresetn is asserted. A busy head tag stalls the FIFO. There is no
  // lookahead past the head, so requests stay in order.
  // --------------------------------------------------------------------------
  assign rd_pop_ready = aresetn
                     && (ar_state == AR_IDLE)
                     && rd_pop_valid
                     && (outstanding < MAX_OUT)
                     && !id_busy[head.tag];

  assign arburst = 2'b01;
  assign ar_hs   = arvalid && arready;

  // --------------------------------------------------------------------------
  // R path: straight pass-through into the response FIFO
  // --------------------------------------------------------------------------
  assign rready          = resp_push_ready;
  assign resp_push_valid = rvalid;
  assign resp_push_data  = {rid, rresp, rlast, rdata};

  assign r_hs     = rvalid && resp_push_ready;
  assign rid_busy = id_busy[rid];
  assign rid_cnt  = id_beat_cnt[rid];
  assign rid_len  = id_exp_len[rid];

  // Only beats on a live ID touch the table.
  assign r_known = r_hs && rid_busy;
  assign r_cmpl  = r_known && rlast;

  // beat_cnt counts beats already accepted. The RLAST beat must therefore
  // arrive when beat_cnt == len. A non-last beat at that count overruns the
  // burst. rresp is deliberately ignored here.
  assign r_err = r_hs && (!rid_busy || (rlast ? (rid_cnt != rid_len)
                                              : (rid_cnt == rid_len)));

  // --------------------------------------------------------------------------
  // AR FSM with registered payload
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_state <= AR_IDLE;
      arvalid  <= 1'b0;
      araddr   <= '0;
      arlen    <= '0;
      arsize   <= '0;
      arid     <= '0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (rd_pop_ready) begin
            araddr   <= head.addr;
            arlen    <= head.len;
            arsize   <= head.size;
            arid     <= head.tag;
            arvalid  <= 1'b1;
            ar_state <= AR_PEND;
          end
        end
        AR_PEND: begin
          // Payload stays frozen until the slave accepts it.
          if (arready) begin
            arvalid  <= 1'b0;
            ar_state <= AR_IDLE;
          end
        end
        default: begin
          arvalid  <= 1'b0;
          ar_state <= AR_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // ID table.
  // The completion update is written before the allocation. When arid == rid
  // in the same cycle, the later non-blocking assignment wins, so the old
  // burst retires first and the new burst then owns the entry.
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      id_busy <= '0;
      for (int i = 0; i < NUM_IDS; i++) begin
        id_exp_len[i]  <= 8'd0;
        id_beat_cnt[i] <= 8'd0;
      end
    end else begin
      if (r_known) begin
        if (rlast) begin
          id_busy[rid]     <= 1'b0;
          id_beat_cnt[rid] <= 8'd0;
        end else begin
          id_beat_cnt[rid] <= rid_cnt + 8'd1;
        end
      end
      if (ar_hs) begin
        id_busy[arid]     <= 1'b1;
        id_exp_len[arid]  <= arlen;
        id_beat_cnt[arid] <= 8'd0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outstanding counter and sticky protocol error.
  // An AR handshake and a completion in the same cycle cancel out. The cap in
  // the pop qualifier bounds the count from above. Completions only come from
  // busy IDs, so the count cannot go below zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding <= '0;
      proto_err   <= 1'b0;
    end else begin
      case ({ar_hs, r_cmpl})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (r_err) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb2axi_rd_engine.sv
module tb_apb2axi_rd_engine;

  localparam int ID_W  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ENT_W = ADDR_W + 8 + 3 + ID_W;
  localparam int OUT_W = 4;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic               rd_pop_valid;
  logic               rd_pop_ready;
  logic [ENT_W-1:0]   rd_pop_data;
  logic               arvalid;
  logic               arready;
  logic [ADDR_W-1:0]  araddr;
  logic [7:0]         arlen;
  logic [2:0]         arsize;
  logic [1:0]         arburst;
  logic [ID_W-1:0]    arid;
  logic               rvalid;
  logic               rready;
  logic [ID_W-1:0]    rid;
  logic [DATA_W-1:0]  rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               resp_push_valid;
  logic               resp_push_ready;
  logic [DATA_W+ID_W+2:0] resp_push_data;
  logic [OUT_W-1:0]   outstanding;
  logic               proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  apb2axi_rd_engine #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .FIFO_ENTRY_W(ENT_W), .MAX_OUTSTANDING(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .rd_pop_valid(rd_pop_valid), .rd_pop_ready(rd_pop_ready), .rd_pop_data(rd_pop_data),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .resp_push_valid(resp_push_valid), .resp_push_ready(resp_push_ready),
    .resp_push_data(resp_push_data),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  function automatic logic [ENT_W-1:0] mk(input logic [31:0] a, input logic [7:0] l,
                                          input logic [2:0] s, input logic [3:0] t);
    return {a, l, s, t};
  endfunction

  // Move to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    step();
    aresetn = 1'b0;
    rd_pop_valid = 1'b0; rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
    resp_push_ready = 1'b1; rresp = 2'b00;
    step();
    step();
    aresetn = 1'b1;
  endtask

  // Pop and issue one read. arready is held high throughout.
  task automatic issue_read(input logic [ENT_W-1:0] e);
    bit got;
    got = 1'b0;
    rd_pop_valid = 1'b1; rd_pop_data = e; arready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rd_pop_ready) begin got = 1'b1; break; end
      step();
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL issue_read_timeout: rd_pop_ready never rose, required 1");
    end
    step();
    rd_pop_valid = 1'b0;
    step();
  endtask

  task automatic send_beats(input logic [3:0] t, input int n);
    for (int b = 0; b < n; b++) begin
      rvalid = 1'b1; rid = t; rdata = 32'hB000_0000 + b; rlast = (b == n - 1);
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %0b want 0", arvalid); end
    n_checks++; if (rd_pop_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pop_ready: got %0b want 0", rd_pop_ready); end
    n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_proto_err: got %0b want 0", proto_err); end
    n_checks++; if ({araddr, arlen, arsize, arid} !== 47'd0) begin n_fail++; $display("FAIL rst_ar_payload: got %0h want 0", {araddr, arlen, arsize, arid}); end
    n_checks++; if (arburst !== 2'b01) begin n_fail++; $display("FAIL rst_arburst: got %0b want 01", arburst); end
    rd_pop_valid = 1'b0;
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    rd_pop_valid = 1'b1; rd_pop_data = mk(32'h1000, 8'd3, 3'd2, 4'd5); arready = 1'b1;
    #1;
    n_checks++; if (rd_pop_ready !== 1'b1) begin n_fail++; $display("FAIL single_pop_ready: got %0b want 1", rd_pop_ready); end
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_pre: got %0b want 0", arvalid); end
    step();
    rd_pop_valid = 1'b0;
    #1;
    n_checks++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL single_arvalid_lat: got %0b want 1", arvalid); end
    n_checks++; if ({araddr, arlen, arsize, arid} !== {32'h1000, 8'd3, 3'd2, 4'd5})
      begin n_fail++; $display("FAIL single_ar_payload: got %0h/%0d/%0d/%0d want 1000/3/2/5", araddr, arlen, arsize, arid); end
    n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL single_out0: got %0d want 0", outstanding); end
    step();
    #1;
    n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL single_out1: got %0d want 1", outstanding); end
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_drop: got %0b want 0", arvalid); end
    for (int b = 0; b < 4; b++) begin
      rvalid = 1'b1; rid = 4'd5; rdata = 32'hA000 + b; rlast = (b == 3);
      #1;
      n_checks++; if (resp_push_valid !== 1'b1 || rready !== 1'b1)
        begin n_fail++; $display("FAIL single_push_hs%0d: got v=%0b r=%0b want 1/1", b, resp_push_valid, rready); end
      n_checks++; if (resp_push_data !== {4'd5, 2'b00, (b == 3) ? 1'b1 : 1'b0, 32'hA000 + b})
        begin n_fail++; $display("FAIL single_push_data%0d: got %0h", b, resp_push_data); end
      step();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL single_out_end: got %0d want 0", outstanding); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL single_proto: got %0b want 0", proto_err); end
  endtask

  task automatic test_ar_backpressure();
    arready = 1'b0;
    rd_pop_valid = 1'b1; rd_pop_data = mk(32'h2040, 8'd1, 3'd3, 4'd6);
    #1;
    n_checks++; if (rd_pop_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop_ready: got %0b want 1", rd_pop_ready); end
    step();
    rd_pop_data = mk(32'h3000, 8'd0, 3'd2, 4'd7);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (arvalid !== 1'b1 || rd_pop_ready !== 1'b0 || araddr !== 32'h2040 || arlen !== 8'd1 || arid !== 4'd6)
        begin n_fail++; $display("FAIL bp_hold%0d: got v=%0b pr=%0b a=%0h l=%0d id=%0d", i, arvalid, rd_pop_ready, araddr, arlen, arid); end
      step();
    end
    arready = 1'b1;
    #1;
    n_checks++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL bp_c6_arvalid: got %0b want 1", arvalid); end
    step();
    #1;
    n_checks++; if (outstanding !== 4'd1 || arvalid !== 1'b0 || rd_pop_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_after_hs: got out=%0d v=%0b pr=%0b want 1/0/1", outstanding, arvalid, rd_pop_ready); end
    step();
    rd_pop_valid = 1'b0;
    step();
    #1;
    n_checks++; if (outstanding !== 4'd2) begin n_fail++; $display("FAIL bp_out2: got %0d want 2", outstanding); end
    send_beats(4'd6, 2);
    send_beats(4'd7, 1);
    #1;
    n_checks++; if (outstanding !== 4'd0 || proto_err !== 1'b0)
      begin n_fail++; $display("FAIL bp_done: got out=%0d err=%0b want 0/0", outstanding, proto_err); end
  endtask

  task automatic test_outstanding_cap();
    int k, hs;
    k = 0; hs = 0;
    arready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rd_pop_data = mk(32'h100 * k, 8'd0, 3'd2, k[3:0]); rd_pop_valid = (k < 10);
      #1;
      if (arvalid && arready) hs++;
      if (rd_pop_ready) k++;
      step();
    end
    rd_pop_data = mk(32'h100 * k, 8'd0, 3'd2, k[3:0]); rd_pop_valid = 1'b1;
    #1;
    n_checks++; if (hs !== 8 || k !== 8) begin n_fail++; $display("FAIL cap_count: got hs=%0d pops=%0d want 8/8", hs, k); end
    n_checks++; if (outstanding !== 4'd8) begin n_fail++; $display("FAIL cap_out: got %0d want 8", outstanding); end
    n_checks++; if (rd_pop_ready !== 1'b0) begin n_fail++; $display("FAIL cap_pop_ready: got %0b want 0", rd_pop_ready); end
    send_beats(4'd0, 1);
    for (int c = 0; c < 6; c++) begin
      rd_pop_data = mk(32'h100 * k, 8'd0, 3'd2, k[3:0]); rd_pop_valid = (k < 10);
      #1;
      if (arvalid && arready) hs++;
      if (rd_pop_ready) k++;
      step();
    end
    rd_pop_valid = 1'b0;
    #1;
    n_checks++; if (hs !== 9 || k !== 9 || outstanding !== 4'd8)
      begin n_fail++; $display("FAIL cap_ninth: got hs=%0d pops=%0d out=%0d want 9/9/8", hs, k, outstanding); end
    for (int t = 1; t <= 8; t++) send_beats(t[3:0], 1);
    #1;
    n_checks++; if (outstanding !== 4'd0 || proto_err !== 1'b0)
      begin n_fail++; $display("FAIL cap_drain: got out=%0d err=%0b want 0/0", outstanding, proto_err); end
  endtask

  task automatic test_tag_reuse();
    issue_read(mk(32'h4000, 8'd1, 3'd2, 4'd2));
    rd_pop_valid = 1'b1; rd_pop_data = mk(32'h5000, 8'd0, 3'd2, 4'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (rd_pop_ready !== 1'b0) begin n_fail++; $display("FAIL reuse_block%0d: got %0b want 0", i, rd_pop_ready); end
      step();
    end
    rvalid = 1'b1; rid = 4'd2; rlast = 1'b0; step();
    rlast = 1'b1;
    #1;
    n_checks++; if (rd_pop_ready !== 1'b0) begin n_fail++; $display("FAIL reuse_last_cycle: got %0b want 0", rd_pop_ready); end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_checks++; if (rd_pop_ready !== 1'b1 || outstanding !== 4'd0)
      begin n_fail++; $display("FAIL reuse_release: got pr=%0b out=%0d want 1/0", rd_pop_ready, outstanding); end
    step();
    rd_pop_valid = 1'b0;
    #1;
    n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h5000 || arid !== 4'd2)
      begin n_fail++; $display("FAIL reuse_second_ar: got v=%0b a=%0h id=%0d want 1/5000/2", arvalid, araddr, arid); end
    step();
    // A pending AR on tag 4 handshakes in the same cycle that tag 2 completes.
    arready = 1'b0;
    rd_pop_valid = 1'b1; rd_pop_data = mk(32'h6000, 8'd0, 3'd2, 4'd4);
    step();
    rd_pop_valid = 1'b0; arready = 1'b1;
    rvalid = 1'b1; rid = 4'd2; rlast = 1'b1;
    #1;
    n_checks++; if (arvalid !== 1'b1 || outstanding !== 4'd1)
      begin n_fail++; $display("FAIL same_cycle_pre: got v=%0b out=%0d want 1/1", arvalid, outstanding); end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_checks++; if (outstanding !== 4'd1 || arvalid !== 1'b0 || proto_err !== 1'b0)
      begin n_fail++; $display("FAIL same_cycle_net: got out=%0d v=%0b err=%0b want 1/0/0", outstanding, arvalid, proto_err); end
    send_beats(4'd4, 1);
    #1;
    n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("FAIL same_cycle_drain: got %0d want 0", outstanding); end
  endtask

  task automatic test_proto_err();
    issue_read(mk(32'h7000, 8'd1, 3'd2, 4'd1));
    send_beats(4'd1, 1);
    #1;
    n_checks++; if (proto_err !== 1'b1 || outstanding !== 4'd0)
      begin n_fail++; $display("FAIL perr_early_last: got err=%0b out=%0d want 1/0", proto_err, outstanding); end
    step(); step(); step();
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %0b want 1", proto_err); end
    // Overrun: a non-last beat after the expected count.
    do_reset();
    #1;
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL perr_rst_clear: got %0b want 0", proto_err); end
    issue_read(mk(32'h7100, 8'd0, 3'd2, 4'd3));
    rvalid = 1'b1; rid = 4'd3; rlast = 1'b0; step();
    rvalid = 1'b0;
    #1;
    n_checks++; if (proto_err !== 1'b1 || outstanding !== 4'd1)
      begin n_fail++; $display("FAIL perr_overrun: got err=%0b out=%0d want 1/1", proto_err, outstanding); end
    send_beats(4'd3, 1);
    // A beat on an idle ID is still forwarded.
    do_reset();
    rvalid = 1'b1; rid = 4'd7; rresp = 2'b10; rlast = 1'b1; rdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (resp_push_valid !== 1'b1 || rready !== 1'b1 || resp_push_data !== {4'd7, 2'b10, 1'b1, 32'hDEADBEEF})
      begin n_fail++; $display("FAIL perr_unexp_fwd: got v=%0b r=%0b d=%0h", resp_push_valid, rready, resp_push_data); end
    step();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    #1;
    n_checks++; if (proto_err !== 1'b1 || outstanding !== 4'd0)
      begin n_fail++; $display("FAIL perr_unexp: got err=%0b out=%0d want 1/0", proto_err, outstanding); end
  endtask

  task automatic test_resp_backpressure_reset();
    do_reset();
    issue_read(mk(32'h8000, 8'd3, 3'd2, 4'd9));
    rresp = 2'b10;
    rvalid = 1'b1; rid = 4'd9; rlast = 1'b0; step();
    resp_push_ready = 1'b0;
    #1;
    n_checks++; if (rready !== 1'b0 || resp_push_valid !== 1'b1)
      begin n_fail++; $display("FAIL rbp_rready: got r=%0b v=%0b want 0/1", rready, resp_push_valid); end
    step(); step();
    n_checks++; if (outstanding !== 4'd1) begin n_fail++; $display("FAIL rbp_out: got %0d want 1", outstanding); end
    resp_push_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      rlast = (b == 3); step();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    #1;
    n_checks++; if (proto_err !== 1'b0 || outstanding !== 4'd0)
      begin n_fail++; $display("FAIL rbp_no_count: got err=%0b out=%0d want 0/0", proto_err, outstanding); end
    // Asynchronous reset in the middle of a burst with an AR pending.
    issue_read(mk(32'h9000, 8'd3, 3'd2, 4'd9));
    rvalid = 1'b1; rid = 4'd9; step();
    rvalid = 1'b0; arready = 1'b0;
    rd_pop_valid = 1'b1; rd_pop_data = mk(32'hA000, 8'd0, 3'd2, 4'd11);
    step();
    #1;
    n_checks++; if (arvalid !== 1'b1 || outstanding !== 4'd1)
      begin n_fail++; $display("FAIL mid_pre: got v=%0b out=%0d want 1/1", arvalid, outstanding); end
    aresetn = 1'b0;
    #1;
    n_checks++; if (arvalid !== 1'b0 || rd_pop_ready !== 1'b0 || outstanding !== 4'd0 || proto_err !== 1'b0 || araddr !== 32'd0)
      begin n_fail++; $display("FAIL mid_reset: got v=%0b pr=%0b out=%0d err=%0b a=%0h want 0/0/0/0/0", arvalid, rd_pop_ready, outstanding, proto_err, araddr); end
    step();
    rd_pop_valid = 1'b0; aresetn = 1'b1;
    rvalid = 1'b1; rid = 4'd9; rlast = 1'b1; step();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_checks++; if (proto_err !== 1'b1 || outstanding !== 4'd0)
      begin n_fail++; $display("FAIL mid_dropped: got err=%0b out=%0d want 1/0", proto_err, outstanding); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0;
    rd_pop_valid = 1'b1; rd_pop_data = mk(32'h1234, 8'd1, 3'd1, 4'd1);
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    resp_push_ready = 1'b1;
    test_reset();
    test_single_read();
    test_ar_backpressure();
    test_outstanding_cap();
    test_tag_reuse();
    test_proto_err();
    test_resp_backpressure_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
